uart_tx_v2: RTL
===============

# uart_tx_v2

Serial transmitter that drives the TxD pin of the MIPS UART: 8 data bits LSB first, one parity bit, then 1 or 2 stop bits. It is the far-end partner of the UART receive block. Its frame format, parity rule and per-bit period match what that receiver samples, so a TxD→RxD loopback reproduces the byte with `PRTY_O`=0. A one-byte holding register double-buffers the CPU write, so back-to-back frames have no idle gap.

## Interface
- `BIT_CYCLES`, 2502: clk cycles per transmitted bit. Equals the receiver's per-bit sampling stride. Minimum 2.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `clk` in 1: clock.
- `clr` in 1: reset, asynchronous, active-high.
- `ld_tx` in 1: load strobe. Accepted only on an edge where `tdre`=1.
- `tx_data` in 8: byte captured on an accepted `ld_tx`.
- `prty_sel` in 1: parity select, captured with `tx_data`. 0 = even, 1 = odd.
- `TxD` out 1: serial line. Idles high.
- `tdre` out 1: transmit data register empty; holding register can accept a byte.
- `busy` out 1: frame in progress (state ≠ IDLE).

## Operation
- **Holding register.** `hold_data[7:0]` and `hold_prty` are written when `ld_tx`=1 and `tdre`=1 at the edge; `tdre` clears on that same edge.
  - `ld_tx` with `tdre`=0 is ignored. Holding register and `tdre` are unchanged.
- **Transfer.** Holding → shift register happens when the holding register is full (`tdre`=0) and the FSM is in IDLE, or is in the last cycle of the final stop bit.
  - Transfer sets `tdre`=1 and latches `parity_bit` = `hold_prty` ^ XOR(`hold_data[7:0]`).
- **Simultaneous transfer and `ld_tx`.** `tdre` is evaluated as registered, so the load is ignored when `tdre` was 0 before the edge. A new load is accepted from the next edge.
- **FSM states.**
  - IDLE: `TxD`=1. On transfer → START.
  - START: `TxD`=0 for `BIT_CYCLES`. → DATA.
  - DATA: `TxD` = `shreg[0]`. Shift right every `BIT_CYCLES`. 8 bits counted by `bit_cnt[3:0]`. → PRTY.
  - PRTY: `TxD` = `parity_bit` for `BIT_CYCLES`. → STOP.
  - STOP: `TxD`=1 for `STOP_BITS`×`BIT_CYCLES`. In its last cycle: if `tdre`=0 → transfer, START; else → IDLE.
- **Counters.**
  - `baud_cnt`: width `$clog2(BIT_CYCLES)`. Runs 0..`BIT_CYCLES`-1 and resets to 0 on every bit boundary.
  - `bit_cnt` is reset on entry to START.
- **Registered outputs.** `TxD` is registered, so no glitches on the pin.
- **`busy`** = (state ≠ IDLE).
- **Reset (`clr`=1, any time including mid-frame).**
  - State IDLE, `TxD`=1, `tdre`=1, `busy`=0.
  - `baud_cnt`, `bit_cnt`, `shreg`, `hold_data`, `hold_prty`, `parity_bit` all 0.
  - The partial frame is abandoned; the line returns high immediately.

## Timing
- Accepted load at edge N: `tdre`=0 after N.
- Edge N+1 (FSM idle): transfer. `TxD`=0, `busy`=1, `tdre`=1 after N+1.
- Bit k of the frame occupies cycles N+1+k·`BIT_CYCLES` … N+(k+1)·`BIT_CYCLES`, with k=0 for start, 1–8 for data, 9 for parity.
- Frame length: (10+`STOP_BITS`)×`BIT_CYCLES` cycles.
  - Default `BIT_CYCLES`=2502, `STOP_BITS`=1: 27522 cycles.
- Back-to-back (holding full before the end of stop): the next start bit begins on the edge immediately after the last stop cycle, with zero idle cycles.
- Otherwise `busy` falls on the edge after the last stop cycle.
- `tdre` is high for the whole frame after transfer, giving the CPU a full frame time to write the next byte.

## Test plan
- **Single byte.** `BIT_CYCLES`=16, load 0x55, `prty_sel`=0.
  - `TxD` sequence, 16 cycles each: 0, 1,0,1,0,1,0,1,0, parity 0, stop 1.
  - `busy` high 176 cycles; `tdre` high again 1 cycle after load.
- **Odd parity.** Load 0x07, `prty_sel`=1 → parity bit 0. Load 0x03, `prty_sel`=1 → parity bit 1.
- **Back-to-back.** Load 0xA5; load 0x3C while frame 1 is in DATA.
  - Second start bit begins exactly 176 cycles after the first. No high gap beyond the one stop bit.
  - `tdre` low between the second load and the second transfer.
- **Overrun ignore.** Load 0x11, then pulse `ld_tx` with 0xFF while `tdre`=0 and the FSM is busy with a prior frame.
  - 0xFF is never transmitted; the holding register still holds 0x11.
- **Reset mid-frame.** Assert `clr` during data bit 4.
  - `TxD`=1, `tdre`=1, `busy`=0 immediately.
  - After release, load 0x81 → a clean full frame.
- **Loopback.** Default `BIT_CYCLES`, `TxD`→receiver `RxD`, bytes 0x00, 0xFF, 0x5A with both `prty_sel` values.
  - Receiver raises `rdrf` with `rx_data` equal to the sent byte and `PRTY_O`=0.
  - `STOP_BITS`=2 passes the same check.

Source files
------------

// File: rtl/uart_tx_v2_if.sv
// CPU-side handshake and serial line of the UART transmitter.
// The master modport is the CPU side and the slave modport is the transmitter.
interface uart_tx_v2_if;
  logic       ld_tx;
  logic [7:0] tx_data;
  logic       prty_sel;
  logic       TxD;
  logic       tdre;
  logic       busy;

  modport master (output ld_tx, tx_data, prty_sel, input TxD, tdre, busy);
  modport slave  (input ld_tx, tx_data, prty_sel, output TxD, tdre, busy);
endinterface

// File: rtl/uart_tx_v2.sv
// UART transmitter: start, 8 data bits LSB first, parity, then 1 or 2 stop bits.
// A one-byte holding register lets the next frame follow the stop bit with no idle gap.
module uart_tx_v2 #(
  parameter int BIT_CYCLES = 2502,
  parameter int STOP_BITS  = 1
) (
  input logic         clk,
  input logic         clr,
  uart_tx_v2_if.slave bus
);

  localparam int            BW        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CYCLES - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PRTY, STOP} state_t;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    hold_data;
  logic          hold_prty;
  logic          parity_bit;
  logic          txd_q;
  logic          tdre_q;

  logic bit_end;
  logic load_ok;
  logic xfer;

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign load_ok = bus.ld_tx && tdre_q;
  // The holding register empties either from idle or right at the end of the final stop bit.
  assign xfer    = !tdre_q && ((state == IDLE) ||
                               ((state == STOP) && bit_end && (bit_cnt == STOP_LAST)));

  assign bus.TxD  = txd_q;
  assign bus.tdre = tdre_q;
  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      hold_data  <= '0;
      hold_prty  <= 1'b0;
      parity_bit <= 1'b0;
      txd_q      <= 1'b1;
      tdre_q     <= 1'b1;
    end else begin
      if (load_ok) begin
        hold_data <= bus.tx_data;
        hold_prty <= bus.prty_sel;
        tdre_q    <= 1'b0;
      end

      if (xfer) begin
        shreg      <= hold_data;
        parity_bit <= hold_prty ^ (^hold_data);
        tdre_q     <= 1'b1;
        state      <= START;
        txd_q      <= 1'b0;
        baud_cnt   <= '0;
        bit_cnt    <= '0;
      end else begin
        if (state == IDLE) begin
          txd_q    <= 1'b1;
          baud_cnt <= '0;
        end else begin
          baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
        end

        // The pin value for the next bit is loaded on the boundary edge, so TxD stays registered.
        if (bit_end) begin
          case (state)
            START: begin
              txd_q   <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= '0;
              state   <= DATA;
            end
            DATA: begin
              if (bit_cnt == 4'd7) begin
                txd_q <= parity_bit;
                state <= PRTY;
              end else begin
                txd_q   <= shreg[0];
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
            PRTY: begin
              txd_q   <= 1'b1;
              bit_cnt <= '0;
              state   <= STOP;
            end
            STOP: begin
              if (bit_cnt == STOP_LAST) begin
                txd_q <= 1'b1;
                state <= IDLE;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
